// File: rtl/sample_ram_writer.sv
// Purpose: captures a burst of valid/ready samples into a single-port RAM at consecutive addresses.
// Latency: a sample accepted at edge N is presented on wr_en/wr_addr/wr_din during cycle N+1.
// Backpressure: in_ready is high for the whole CAPTURE state; the RAM side never stalls.
module sample_ram_writer #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH-1:0] length_m1,
  input  logic                     abort,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_din,
  output logic                     busy,
  output logic                     done
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]               state;
  logic [ADDRESS_WIDTH-1:0] ptr;
  logic [ADDRESS_WIDTH-1:0] cnt;
  logic [ADDRESS_WIDTH-1:0] limit;
  logic                     accept;

  // Status and handshake decode straight from the state register.
  always_comb begin
    in_ready = (state == CAPTURE);
    busy     = (state == CAPTURE);
    done     = (state == DONE);
    accept   = in_valid & in_ready & ~abort;
  end

  // Burst sequencing: pointer/counter/limit bookkeeping and state transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      limit <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr   <= base_addr;
            limit <= length_m1;
            cnt   <= '0;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (abort) begin
            state <= IDLE;
          end else if (accept) begin
            // Pointer wraps naturally modulo the RAM depth.
            ptr <= ptr + ADDRESS_WIDTH'(1);
            cnt <= cnt + ADDRESS_WIDTH'(1);
            if (cnt == limit) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM write port register: strobe every accept, hold address/data otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_din  <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= ptr;
        wr_din  <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_sample_ram_writer.sv
// Directed bench for sample_ram_writer: reset, bursts, wrap, gaps, abort, ignored controls.
// Inputs change 1 time unit after each rising edge; outputs are checked at that same point.
// Every expected value below is hand-derived from the burst parameters used in each step.
module tb_sample_ram_writer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] length_m1;
  logic       abort;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_din;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  sample_ram_writer #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length_m1 (length_m1),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_din    (wr_din),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Gapped-input pattern and the write each cycle should show one edge later.
  logic [5:0] gap_vld  = 6'b101001;                 // bit i = in_valid in cycle i (1,0,0,1,0,1)
  logic [7:0] gap_addr [6] = '{8'h20, 8'h20, 8'h20, 8'h21, 8'h21, 8'h22};
  logic [7:0] gap_din  [6] = '{8'hC0, 8'hC0, 8'hC0, 8'hC3, 8'hC3, 8'hC5};

  initial begin
    int done_count;
    logic [7:0] exp_a;
    logic [7:0] exp_d;

    // ---------------- reset with random inputs ----------------
    rst_n = 1'b0;
    start = 1'b0; base_addr = '0; length_m1 = '0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < 4; i++) begin
      start     = 1'($urandom);
      base_addr = 8'($urandom);
      length_m1 = 8'($urandom);
      abort     = 1'($urandom);
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      step();
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_din", wr_din, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    start = 1'b0; abort = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    rst_n = 1'b1;

    // Idle with abort and in_valid high: nothing may happen.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_wr_en", wr_en, 0);
      chk("idle_busy", busy, 0);
    end
    abort = 1'b0; in_valid = 1'b0;

    // ---------------- basic burst with ignored mid-burst start ----------------
    start = 1'b1; base_addr = 8'h10; length_m1 = 8'd3;
    step();
    chk("basic_busy", busy, 1);
    chk("basic_in_ready", in_ready, 1);
    chk("basic_no_wr", wr_en, 0);
    start = 1'b0; in_valid = 1'b1; in_data = 8'hA0;
    step();
    chk("basic_en0", wr_en, 1); chk("basic_addr0", wr_addr, 8'h10); chk("basic_din0", wr_din, 8'hA0);
    in_data = 8'hA1; start = 1'b1; base_addr = 8'h80; length_m1 = 8'd0;
    step();
    chk("basic_en1", wr_en, 1); chk("basic_addr1", wr_addr, 8'h11); chk("basic_din1", wr_din, 8'hA1);
    chk("basic_done1", done, 0);
    start = 1'b0; in_data = 8'hA2;
    step();
    chk("basic_addr2", wr_addr, 8'h12); chk("basic_din2", wr_din, 8'hA2); chk("basic_done2", done, 0);
    in_data = 8'hA3;
    step();
    chk("basic_en3", wr_en, 1); chk("basic_addr3", wr_addr, 8'h13); chk("basic_din3", wr_din, 8'hA3);
    chk("basic_done3", done, 1); chk("basic_busy3", busy, 0); chk("basic_rdy3", in_ready, 0);
    in_data = 8'hA4; start = 1'b1; base_addr = 8'h55;   // start during DONE: ignored
    step();
    chk("basic_after_en", wr_en, 0); chk("basic_after_busy", busy, 0); chk("basic_after_done", done, 0);
    chk("basic_hold_addr", wr_addr, 8'h13); chk("basic_hold_din", wr_din, 8'hA3);
    start = 1'b0; in_valid = 1'b0;
    step();
    chk("basic_idle_busy", busy, 0);

    // ---------------- minimum burst, back-to-back ----------------
    start = 1'b1; base_addr = 8'h40; length_m1 = 8'd0; in_valid = 1'b1; in_data = 8'h5A;
    step();
    chk("min_busy", busy, 1);
    start = 1'b0;
    step();
    chk("min_en", wr_en, 1); chk("min_addr", wr_addr, 8'h40); chk("min_din", wr_din, 8'h5A);
    chk("min_done", done, 1);
    step();
    chk("min_idle_en", wr_en, 0); chk("min_idle_busy", busy, 0);
    start = 1'b1; base_addr = 8'h41; in_data = 8'h5B;
    step();
    chk("min2_busy", busy, 1);
    start = 1'b0;
    step();
    chk("min2_addr", wr_addr, 8'h41); chk("min2_din", wr_din, 8'h5B); chk("min2_done", done, 1);
    in_valid = 1'b0;
    step();

    // ---------------- gapped input ----------------
    start = 1'b1; base_addr = 8'h20; length_m1 = 8'd2;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = gap_vld[i];
      in_data  = 8'hC0 + 8'(i);
      step();
      chk("gap_en", wr_en, 32'(gap_vld[i]));
      chk("gap_addr", wr_addr, gap_addr[i]);
      chk("gap_din", wr_din, gap_din[i]);
      chk("gap_done", done, (i == 5) ? 1 : 0);
    end
    in_valid = 1'b0;
    step();
    chk("gap_idle_en", wr_en, 0); chk("gap_idle_busy", busy, 0);

    // ---------------- abort on the third sample ----------------
    start = 1'b1; base_addr = 8'h30; length_m1 = 8'd7;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = 8'hD0;
    step();
    chk("ab_addr0", wr_addr, 8'h30); chk("ab_din0", wr_din, 8'hD0);
    in_data = 8'hD1;
    step();
    chk("ab_addr1", wr_addr, 8'h31); chk("ab_din1", wr_din, 8'hD1);
    in_data = 8'hD2; abort = 1'b1;
    step();
    chk("ab_en", wr_en, 0); chk("ab_busy", busy, 0); chk("ab_done", done, 0);
    chk("ab_hold_addr", wr_addr, 8'h31); chk("ab_hold_din", wr_din, 8'hD1);
    abort = 1'b0;
    step();
    chk("ab_idle_en", wr_en, 0); chk("ab_idle_done", done, 0);
    start = 1'b1; base_addr = 8'h60; length_m1 = 8'd1; in_data = 8'hE0;
    step();
    chk("ab_restart_busy", busy, 1);
    start = 1'b0;
    step();
    chk("ab_re_addr0", wr_addr, 8'h60); chk("ab_re_din0", wr_din, 8'hE0);
    in_data = 8'hE1;
    step();
    chk("ab_re_addr1", wr_addr, 8'h61); chk("ab_re_din1", wr_din, 8'hE1); chk("ab_re_done", done, 1);
    in_valid = 1'b0;
    step();

    // ---------------- full depth with address wrap ----------------
    start = 1'b1; base_addr = 8'hFE; length_m1 = 8'hFF;
    step();
    start = 1'b0; in_valid = 1'b1;
    done_count = 0;
    for (int i = 0; i < 256; i++) begin
      in_data = 8'(i) ^ 8'h5A;
      step();
      exp_a = 8'hFE + 8'(i);
      exp_d = 8'(i) ^ 8'h5A;
      if (done) done_count++;
      chk("full_en", wr_en, 1);
      chk("full_addr", wr_addr, exp_a);
      chk("full_din", wr_din, exp_d);
    end
    step();
    if (done) done_count++;
    chk("full_done_count", done_count, 1);
    chk("full_idle_en", wr_en, 0);
    chk("full_idle_busy", busy, 0);
    in_valid = 1'b0;

    // ---------------- reset mid-burst ----------------
    start = 1'b1; base_addr = 8'h70; length_m1 = 8'd5;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = 8'hB0;
    step();
    chk("mrst_pre_en", wr_en, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_en", wr_en, 0); chk("mrst_addr", wr_addr, 0); chk("mrst_din", wr_din, 0);
    chk("mrst_busy", busy, 0); chk("mrst_rdy", in_ready, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("mrst_after_en", wr_en, 0); chk("mrst_after_busy", busy, 0);
    in_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
